// File: rtl/video_mode_ctrl_if.sv
// Camera/sender side signal bundle for video_mode_ctrl.
// master drives the camera and sender inputs; slave is the controller.
interface video_mode_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             frame_enable;
    logic             clk_enable;
    logic [1:0]       mode_req;
    logic             mode_req_valid;
    logic             tx_ack;
    logic             binary_enable1;
    logic             binary_enable2;
    logic [1:0]       active_mode;
    logic             tx_req;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output frame_enable, clk_enable, mode_req, mode_req_valid, tx_ack,
        input  binary_enable1, binary_enable2, active_mode, tx_req,
        input  frame_cnt, err_cnt
    );

    modport slave (
        input  frame_enable, clk_enable, mode_req, mode_req_valid, tx_ack,
        output binary_enable1, binary_enable2, active_mode, tx_req,
        output frame_cnt, err_cnt
    );
endinterface

// File: rtl/video_mode_ctrl.sv
// Frame sequencer: applies pixel-stage modes only in blanking,
// validates frame pixel counts and hands good frames to the sender.
module video_mode_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int PIX_CNT_W   = 19,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    video_mode_ctrl_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PIX_CNT_W-1:0] FRAME_PIX = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [WD_W-1:0]      WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        WAIT_GAP,
        WAIT_START,
        ACTIVE,
        CHECK,
        TX
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_fe_d;
    logic [1:0]           r_pending;
    logic [1:0]           r_active_mode;
    logic                 r_en1;
    logic                 r_en2;
    logic                 r_tx_req;
    logic [CNT_W-1:0]     r_frame_cnt;
    logic [CNT_W-1:0]     r_err_cnt;
    logic [PIX_CNT_W-1:0] r_pix_cnt;
    logic [WD_W-1:0]      r_wdog;

    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_frame_ok;
    logic w_err;
    logic w_tx_clr;

    assign w_rise = bus.frame_enable & ~r_fe_d;
    assign w_fall = ~bus.frame_enable & r_fe_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= WAIT_GAP;
        else     r_state <= w_state_nxt;
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame_ok  = 1'b0;
        w_err       = 1'b0;
        w_tx_clr    = 1'b0;
        case (r_state)
            WAIT_GAP: begin
                if (!bus.frame_enable) w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (w_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_fall) begin
                    w_state_nxt = CHECK;
                end else if (r_wdog == WD_LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = WAIT_GAP;
                end
            end
            CHECK: begin
                if (r_pix_cnt == FRAME_PIX) begin
                    w_frame_ok  = 1'b1;
                    w_state_nxt = TX;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = WAIT_START;
                end
            end
            TX: begin
                if (bus.tx_ack) begin
                    w_tx_clr    = 1'b1;
                    w_state_nxt = WAIT_GAP;
                end
            end
            default: w_state_nxt = WAIT_GAP;
        endcase
    end

    // Mode request capture and blanking-only apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fe_d        <= 1'b0;
            r_pending     <= 2'd0;
            r_active_mode <= 2'd0;
            r_en1         <= 1'b0;
            r_en2         <= 1'b0;
        end else begin
            r_fe_d <= bus.frame_enable;
            if (bus.mode_req_valid && bus.mode_req != 2'd3)
                r_pending <= bus.mode_req;
            if (r_state == WAIT_START && !bus.frame_enable)
                r_active_mode <= r_pending;
            r_en1 <= (r_active_mode == 2'd2);
            r_en2 <= (r_active_mode == 2'd1);
        end
    end

    // Pixel counter and watchdog for the frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt <= '0;
            r_wdog    <= '0;
        end else if (w_start) begin
            r_pix_cnt <= {{(PIX_CNT_W-1){1'b0}}, bus.clk_enable};
            r_wdog    <= '0;
        end else if (r_state == ACTIVE) begin
            if (bus.clk_enable && r_pix_cnt != '1)
                r_pix_cnt <= r_pix_cnt + 1'b1;
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Result counters and sender request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_tx_req    <= 1'b0;
        end else begin
            if (w_frame_ok)
                r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_err && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
            if (w_frame_ok)
                r_tx_req <= 1'b1;
            else if (w_tx_clr)
                r_tx_req <= 1'b0;
        end
    end

    assign bus.binary_enable1 = r_en1;
    assign bus.binary_enable2 = r_en2;
    assign bus.active_mode    = r_active_mode;
    assign bus.tx_req         = r_tx_req;
    assign bus.frame_cnt      = r_frame_cnt;
    assign bus.err_cnt        = r_err_cnt;
endmodule
